// File: rtl/alu_share_sched.sv
// rtl/alu_share_sched.sv - round-robin scheduler sharing one 8-bit ALU between two requesters
module alu_share_sched #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4,
  parameter int MAX_OP = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_n,
  input  logic              alu_z,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_y,
  output logic [3:0]        resp_flags,
  output logic              resp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OP_W-1:0] MAX_CODE = OP_W'(MAX_OP);

  state_t     state;
  state_t     stateNext;
  logic [1:0] grant;
  logic       last;
  logic       owner;
  logic       opIllegal;

  // The ALU operand registers double as the latched request, so the
  // function code being executed is what decides legality.
  assign opIllegal  = (alu_ctrl > MAX_CODE);
  assign req_ready  = grant;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and grant: round-robin favours the requester that was not served last.
  always_comb begin
    grant     = 2'b00;
    stateNext = state;
    case (state)
      IDLE: begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = last ? 2'b01 : 2'b10;
          default: grant = 2'b00;
        endcase
        if (grant != 2'b00) begin
          stateNext = EXEC;
        end
      end
      EXEC: stateNext = RESP;
      RESP: begin
        if (resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: latch the winning request, then capture the ALU result one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      last       <= 1'b1;
      owner      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      resp_id    <= 1'b0;
      resp_y     <= '0;
      resp_flags <= 4'b0000;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            owner    <= grant[1];
            alu_a    <= grant[1] ? req_a1  : req_a0;
            alu_b    <= grant[1] ? req_b1  : req_b0;
            alu_ctrl <= grant[1] ? req_op1 : req_op0;
          end
        end
        EXEC: begin
          resp_id <= owner;
          last    <= owner;
          if (opIllegal) begin
            resp_y     <= '0;
            resp_flags <= 4'b0000;
            resp_err   <= 1'b1;
          end else begin
            resp_y     <= alu_y;
            resp_flags <= {alu_c, alu_v, alu_n, alu_z};
            resp_err   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_sched.sv
// tb/tb_alu_share_sched.sv - randomized self-checking bench for alu_share_sched
module tb_alu_share_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0] req_op0, req_op1;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_ctrl;
  logic       alu_c, alu_v, alu_n, alu_z;
  logic       resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [7:0] resp_y;
  logic [3:0] resp_flags;

  int vectors = 0;
  int miscompares = 0;

  alu_share_sched #(.DATA_W(8), .OP_W(4), .MAX_OP(7)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_c(alu_c), .alu_v(alu_v), .alu_n(alu_n), .alu_z(alu_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_y(resp_y), .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {C,V,N,Z,Y}; codes above 7 produce junk the scheduler must discard.
  function automatic logic [11:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [8:0] wide;
    logic [7:0] y;
    logic c, v, n;
    c = 1'b0; v = 1'b0; n = 1'b0;
    case (op)
      4'd0: begin
        wide = {1'b0, a} + {1'b0, b};
        y = wide[7:0]; c = wide[8]; n = y[7];
        v = (a[7] == b[7]) && (y[7] != a[7]);
      end
      4'd1: begin
        wide = {1'b0, a} - {1'b0, b};
        y = wide[7:0]; c = wide[8]; n = y[7];
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      4'd2: y = a & b;
      4'd3: y = a | b;
      4'd4: y = a ^ b;
      4'd5: y = a << b[2:0];
      4'd6: y = a >> b[2:0];
      4'd7: y = a & ~b;
      default: return {4'hF, 8'hA5};
    endcase
    return {c, v, n, (y == 8'h00), y};
  endfunction

  // Expected response {err, flags, y} for a request.
  function automatic logic [12:0] expectResp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if (op > 4'd7) return {1'b1, 12'h000};
    return {1'b0, aluModel(a, b, op)};
  endfunction

  // Environment ALU.
  always_comb begin
    {alu_c, alu_v, alu_n, alu_z, alu_y} = aluModel(alu_a, alu_b, alu_ctrl);
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic setPayload(input int port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    if (port == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op;
    end
  endtask

  // Present a request, wait for its grant edge, then withdraw; ends mid-EXEC.
  task automatic issue(input int port, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, output bit ok);
    ok = 1'b0;
    setPayload(port, a, b, op);
    req_valid[port] = 1'b1;
    #1;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (req_ready[port]) ok = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    req_valid[port] = 1'b0;
    #1;
  endtask

  task automatic waitResp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (resp_valid) ok = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic finishResp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if ({req_ready, resp_valid, busy, resp_id, resp_y, resp_flags, resp_err, alu_a, alu_b, alu_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got ready=%b valid=%b busy=%b id=%b y=%h f=%b err=%b a=%h b=%h ctrl=%h, expected all zero",
               req_ready, resp_valid, busy, resp_id, resp_y, resp_flags, resp_err, alu_a, alu_b, alu_ctrl);
    end
  endtask

  task automatic test_single();
    doReset();
    setPayload(0, 8'h7F, 8'h01, 4'd0);
    req_valid = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    vectors++;
    if ({req_ready, busy, resp_valid, alu_a, alu_b, alu_ctrl} !== {2'b00, 1'b1, 1'b0, 8'h7F, 8'h01, 4'd0}) begin
      miscompares++;
      $display("FAIL single_exec: got ready=%b busy=%b valid=%b a=%h b=%h ctrl=%h expected 00 1 0 7f 01 0",
               req_ready, busy, resp_valid, alu_a, alu_b, alu_ctrl);
    end
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid, resp_id, resp_err, resp_flags, resp_y} !== {1'b1, 1'b0, 1'b0, 4'b0110, 8'h80}) begin
      miscompares++;
      $display("FAIL single_resp: got valid=%b id=%b err=%b f=%b y=%h expected 1 0 0 0110 80",
               resp_valid, resp_id, resp_err, resp_flags, resp_y);
    end
    finishResp();
    vectors++;
    if ({resp_valid, busy} !== 2'b00) begin
      miscompares++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_contention();
    logic [13:0] expQ[$];
    logic [13:0] e;
    bit lastModel;
    int grants, resps, lastGrant, lastResp, pending, port;
    doReset();
    lastModel = 1'b1;
    grants = 0; resps = 0; lastGrant = -1; lastResp = -1; pending = -1;
    resp_ready = 1'b1;
    setPayload(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    setPayload(1, 8'h05, 8'h05, 4'd1);
    req_valid = 2'b11;
    for (int cyc = 0; cyc < 60 && resps < 6; cyc++) begin
      #1;
      if (resp_valid) begin
        vectors++;
        e = (expQ.size() != 0) ? expQ.pop_front() : 14'h3FFF;
        if ({resp_id, resp_err, resp_flags, resp_y} !== e) begin
          miscompares++;
          $display("FAIL contention_resp%0d: got id=%b err=%b f=%b y=%h expected %h",
                   resps, resp_id, resp_err, resp_flags, resp_y, e);
        end
        if (lastResp >= 0) begin
          vectors++;
          if (cyc - lastResp !== 3) begin
            miscompares++; $display("FAIL contention_resp_gap: got %0d expected 3", cyc - lastResp);
          end
        end
        lastResp = cyc;
        resps++;
      end
      if (req_ready != 2'b00) begin
        vectors++;
        if (req_ready !== (lastModel ? 2'b01 : 2'b10)) begin
          miscompares++;
          $display("FAIL contention_grant%0d: got %b expected %b", grants, req_ready, lastModel ? 2'b01 : 2'b10);
        end
        port = req_ready[1] ? 1 : 0;
        lastModel = req_ready[1];
        if (port == 0) expQ.push_back({1'b0, expectResp(req_a0, req_b0, req_op0)});
        else expQ.push_back({1'b1, expectResp(req_a1, req_b1, req_op1)});
        if (lastGrant >= 0) begin
          vectors++;
          if (cyc - lastGrant !== 3) begin
            miscompares++; $display("FAIL contention_grant_gap: got %0d expected 3", cyc - lastGrant);
          end
        end
        lastGrant = cyc;
        grants++;
        pending = port;
      end
      @(negedge clk);
      if (pending == 0) setPayload(0, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
      pending = -1;
      if (grants >= 6) req_valid = 2'b00;
    end
    vectors++;
    if (resps !== 6) begin
      miscompares++; $display("FAIL contention_count: got %0d responses expected 6", resps);
    end
    resp_ready = 1'b0;
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_backpressure();
    logic [7:0] a, b;
    logic [3:0] op;
    logic [12:0] exp;
    bit ok;
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 7));
    exp = expectResp(a, b, op);
    issue(0, a, b, op, ok);
    if (ok) waitResp(ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL backpressure_start: got no response expected one");
    end
    setPayload(1, 8'($urandom), 8'($urandom), 4'd2);
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({resp_valid, resp_id, req_ready, resp_err, resp_flags, resp_y} !== {1'b1, 1'b0, 2'b00, exp}) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: got valid=%b id=%b ready=%b err=%b f=%b y=%h expected 1 0 00 %h",
                 k, resp_valid, resp_id, req_ready, resp_err, resp_flags, resp_y, exp);
      end
      @(negedge clk); #1;
    end
    resp_ready = 1'b1;
    #1;
    vectors++;
    if ({resp_valid, req_ready} !== 3'b100) begin
      miscompares++; $display("FAIL backpressure_handshake: got valid=%b ready=%b expected 1 00", resp_valid, req_ready);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    vectors++;
    if ({resp_valid, req_ready} !== 3'b010) begin
      miscompares++; $display("FAIL backpressure_done: got valid=%b ready=%b expected 0 10", resp_valid, req_ready);
    end
    req_valid = 2'b00;
    #1;
    @(negedge clk); #1;
    vectors++;
    if ({busy, req_ready} !== 3'b000) begin
      miscompares++; $display("FAIL withdraw: got busy=%b ready=%b expected 0 00", busy, req_ready);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    issue(1, 8'($urandom), 8'($urandom), 4'hC, ok);
    if (ok) waitResp(ok);
    vectors++;
    if ({ok, resp_id, resp_err, resp_flags, resp_y} !== {1'b1, 1'b1, 1'b1, 4'b0000, 8'h00}) begin
      miscompares++;
      $display("FAIL illegal: got ok=%b id=%b err=%b f=%b y=%h expected 1 1 1 0000 00", ok, resp_id, resp_err, resp_flags, resp_y);
    end
    finishResp();
  endtask

  task automatic test_logic();
    bit ok;
    logic [12:0] exp;
    exp = expectResp(8'h81, 8'h10, 4'd7);
    issue(0, 8'h81, 8'h10, 4'd7, ok);
    if (ok) waitResp(ok);
    vectors++;
    if ({ok, resp_id, resp_err, resp_flags, resp_y} !== {1'b1, 1'b0, exp}) begin
      miscompares++;
      $display("FAIL logic_op7: got ok=%b id=%b err=%b f=%b y=%h expected 1 0 %h", ok, resp_id, resp_err, resp_flags, resp_y, exp);
    end
    vectors++;
    if (resp_flags[3:1] !== 3'b000) begin
      miscompares++; $display("FAIL logic_cvn: got %b expected 000", resp_flags[3:1]);
    end
    finishResp();
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] a, b;
    logic [3:0] op;
    issue(0, 8'($urandom), 8'($urandom), 4'd3, ok);
    if (ok) waitResp(ok);
    finishResp();
    issue(0, 8'($urandom), 8'($urandom), 4'd0, ok);
    vectors++;
    if ({ok, busy} !== 2'b11) begin
      miscompares++; $display("FAIL resetmid_exec: got ok=%b busy=%b expected 1 1", ok, busy);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({req_ready, resp_valid, busy, resp_id, resp_y, resp_flags, resp_err, alu_a, alu_b, alu_ctrl} !== '0) begin
      miscompares++;
      $display("FAIL resetmid_clear: got valid=%b busy=%b id=%b y=%h f=%b err=%b a=%h b=%h ctrl=%h expected all zero",
               resp_valid, busy, resp_id, resp_y, resp_flags, resp_err, alu_a, alu_b, alu_ctrl);
    end
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (resp_valid !== 1'b0) begin
        miscompares++; $display("FAIL resetmid_noresp%0d: got %b expected 0", k, resp_valid);
      end
    end
    a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 7));
    setPayload(0, a, b, op);
    setPayload(1, 8'($urandom), 8'($urandom), 4'd4);
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++; $display("FAIL resetmid_pointer: got %b expected 01", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    waitResp(ok);
    vectors++;
    if ({ok, resp_id, resp_err, resp_flags, resp_y} !== {1'b1, 1'b0, expectResp(a, b, op)}) begin
      miscompares++;
      $display("FAIL resetmid_after: got ok=%b id=%b err=%b f=%b y=%h expected 1 0 %h",
               ok, resp_id, resp_err, resp_flags, resp_y, expectResp(a, b, op));
    end
    finishResp();
  endtask

  task automatic test_random();
    bit ok;
    int port;
    logic [7:0] a, b;
    logic [3:0] op;
    for (int n = 0; n < 20; n++) begin
      port = $urandom_range(0, 1);
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 15));
      issue(port, a, b, op, ok);
      if (ok) waitResp(ok);
      vectors++;
      if ({ok, resp_id, resp_err, resp_flags, resp_y} !== {1'b1, port[0], expectResp(a, b, op)}) begin
        miscompares++;
        $display("FAIL random%0d: got ok=%b id=%b err=%b f=%b y=%h expected 1 %0d %h",
                 n, ok, resp_id, resp_err, resp_flags, resp_y, port, expectResp(a, b, op));
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) begin
        @(negedge clk); #1;
      end
      finishResp();
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; resp_ready = 1'b0;
    req_a0 = '0; req_b0 = '0; req_op0 = '0;
    req_a1 = '0; req_b1 = '0; req_op1 = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal();
    test_logic();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
